// File: rtl/me_best_sad_serializer.sv
// Per-channel minimum-SAD tracker with a serial LSB-first result port.
// Define ME_TIE_HIGH_EN to resolve equal SADs to the highest candidate index.
module me_best_sad_serializer #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned NUM_CAND = 9,
    parameter int unsigned SAD_W    = 24,
    parameter int unsigned PT_W     = 4,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic             cand_valid,
    input  logic [CH_W-1:0]  cand_ch,
    input  logic [SAD_W-1:0] cand_sad,
    output logic             busy,
    output logic             err,
    output logic             out_valid,
    output logic             out_sad
);

    localparam int unsigned ENT_W = SAD_W + PT_W;
    localparam int unsigned TOT_W = NUM_CH * ENT_W;
    localparam int unsigned CNT_W = $clog2(NUM_CAND + 1);
    localparam int unsigned REM_W = $clog2(TOT_W);

    typedef enum logic [1:0] {StIdle, StCollect, StSerial} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [SAD_W-1:0]   min_q [NUM_CH];
    logic [PT_W-1:0]    pt_q  [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [SAD_W-1:0]   min_d [NUM_CH];
    logic [PT_W-1:0]    pt_d  [NUM_CH];
    logic [TOT_W-1:0]   sh_q;
    logic [TOT_W-1:0]   packed_d;
    logic [REM_W-1:0]   rem_q;
    logic               accept;
    logic               illegal;
    logic               all_full;
    logic               replace;

    // in_start takes priority over a concurrent candidate, which is silently dropped.
    assign accept = cand_valid && !in_start && (state_q == StCollect);

    always_comb begin
        illegal  = 1'b0;
        all_full = 1'b1;
        replace  = 1'b0;
        packed_d = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cnt_d[c] = cnt_q[c];
            min_d[c] = min_q[c];
            pt_d[c]  = pt_q[c];
        end
        if (accept) begin
            if (32'(cand_ch) >= NUM_CH) begin
                illegal = 1'b1;
            end
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (cand_ch == CH_W'(c)) begin
                    if (cnt_q[c] == CNT_W'(NUM_CAND)) begin
                        illegal = 1'b1;
                    end else begin
`ifdef ME_TIE_HIGH_EN
                        replace = (cnt_q[c] == '0) || (cand_sad <= min_q[c]);
`else
                        replace = (cnt_q[c] == '0) || (cand_sad < min_q[c]);
`endif
                        if (replace) begin
                            min_d[c] = cand_sad;
                            pt_d[c]  = PT_W'(cnt_q[c]);
                        end
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    end
                end
            end
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            all_full = all_full && (cnt_d[c] == CNT_W'(NUM_CAND));
            packed_d[c*ENT_W +: SAD_W]       = min_d[c];
            packed_d[c*ENT_W + SAD_W +: PT_W] = pt_d[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_sad   <= 1'b0;
            sh_q      <= '0;
            rem_q     <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                cnt_q[c] <= '0;
                min_q[c] <= '0;
                pt_q[c]  <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle, StCollect: begin
                    if (in_start) begin
                        state_q <= StCollect;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        for (int c = 0; c < int'(NUM_CH); c++) begin
                            cnt_q[c] <= '0;
                            min_q[c] <= '0;
                            pt_q[c]  <= '0;
                        end
                    end else if (state_q == StCollect) begin
                        for (int c = 0; c < int'(NUM_CH); c++) begin
                            cnt_q[c] <= cnt_d[c];
                            min_q[c] <= min_d[c];
                            pt_q[c]  <= pt_d[c];
                        end
                        if (illegal) begin
                            err <= 1'b1;
                        end
                        // Load the word including this edge's candidate so bit 0 leaves at once.
                        if (all_full) begin
                            state_q   <= StSerial;
                            out_valid <= 1'b1;
                            out_sad   <= packed_d[0];
                            sh_q      <= packed_d >> 1;
                            rem_q     <= REM_W'(TOT_W - 1);
                        end
                    end
                end
                StSerial: begin
                    if (rem_q == '0) begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_sad   <= 1'b0;
                    end else begin
                        out_sad <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                        rem_q   <= rem_q - REM_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/me_best_sad_serializer.md
# me_best_sad_serializer

Parametrised best-match selector and serial result port for the motion-estimation datapath. It collects a fixed number of candidate SAD values per channel and tracks the minimum SAD and its candidate index in each channel. It then shifts the packed result out one bit per cycle under `out_valid`. It sits between the SAD engine and the top-level `out_valid`/`out_sad` pins and generalises the fixed two-channel, 56-bit result stream to N channels, configurable widths and configurable candidate counts.

## Interface
- `NUM_CH`, 2: number of independent channels (motion-vector pairs).
- `NUM_CAND`, 9: candidates per channel. Index range 0..NUM_CAND-1.
- `SAD_W`, 24: SAD width.
- `PT_W`, 4: point-index width. Must satisfy 2^PT_W ≥ NUM_CAND.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_start` in 1: one-cycle pulse that clears all trackers and opens a new collection.
- `cand_valid` in 1: candidate strobe.
- `cand_ch` in max(1,$clog2(NUM_CH)): channel of the candidate.
- `cand_sad` in SAD_W: candidate SAD. The candidate index is implicit: the arrival order within its channel.
- `busy` out 1: high in COLLECT and SERIAL.
- `err` out 1: sticky overflow/illegal-candidate flag. Cleared by `in_start` or reset.
- `out_valid` out 1: serial output qualifier.
- `out_sad` out 1: serial result bit. Must be 0 whenever `out_valid` is 0.

## Operation
- States: IDLE, COLLECT, SERIAL.
- IDLE:
  - `in_start` → COLLECT. Clears per-channel counters, minima and `err`.
  - Candidates are ignored.
- COLLECT:
  - Each accepted candidate goes to channel `cand_ch`. Its index is that channel's counter value, and the counter then increments.
  - The first candidate of a channel loads the minimum unconditionally.
  - Later candidates replace the minimum only if `cand_sad` < min. Ties keep the earlier (lower) index.
  - `in_start` in COLLECT restarts the collection with the same clearing as from IDLE.
- Illegal candidates are dropped, do not increment any counter, and set `err`. A candidate is illegal when:
  - its channel already holds NUM_CAND candidates, or
  - `cand_ch` ≥ NUM_CH.
- When every channel holds NUM_CAND candidates → SERIAL.
- SERIAL:
  - Shifts exactly NUM_CH*(SAD_W+PT_W) bits, contiguous, `out_valid` high throughout.
  - Bit order is the packed word {pt[NUM_CH-1], sad[NUM_CH-1], …, pt[0], sad[0]} sent LSB first: ch0 SAD bit0..SAD_W-1, then ch0 point bit0..PT_W-1, then ch1, and so on.
  - `in_start` and `cand_valid` are ignored in SERIAL. No `err` is raised.
  - After the last bit → IDLE.
- Simultaneous `in_start` and `cand_valid`: `in_start` wins and the candidate is dropped without setting `err`.
- Reset mid-operation: immediate return to IDLE. All outputs go to 0 and all stored results are discarded.

## Timing
- Reset values: `busy`=0, `err`=0, `out_valid`=0, `out_sad`=0. State is IDLE.
- Inputs are sampled on the rising edge. `in_start` at edge k gives `busy`=1 after edge k.
- Candidate compare and update complete at the accepting edge. The tracker adds no pipeline latency.
- Final candidate accepted at edge k: `out_valid` rises after edge k and carries bit 0. The last bit is during cycle k+NUM_CH*(SAD_W+PT_W).
- `out_valid` and `busy` fall together after the last bit. `out_sad` is forced to 0 in the same cycle.
- Earliest new collection: `in_start` in the first IDLE cycle after SERIAL.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `ME_TIE_HIGH_EN`:
  - Defined: an equal SAD replaces the stored minimum, so ties resolve to the highest index.
  - Undefined (default): ties keep the lowest index.
- All other behaviour is identical in both builds.

## Test plan
- Defaults, basic run:
  - Stimulus: `in_start`, then interleaved candidates. ch0 SADs 50,40,40,60,70,80,90,100,110. ch1 SADs 7,6,5,4,3,2,1,0,9.
  - Required: 56-bit stream with ch0 sad=40, pt=1 and ch1 sad=0, pt=7, LSB first. `out_valid` high for exactly 56 cycles, starting one cycle after the last accept.
- Same stimulus built with `ME_TIE_HIGH_EN`: ch0 pt=2.
- Overflow:
  - Stimulus: a 10th candidate to ch0 (SAD 0) before ch1 completes.
  - Required: `err`=1, ch0 result unchanged, stream still 56 bits.
- Simultaneous `in_start` and `cand_valid`, then a fresh full set of candidates:
  - Required: the candidate concurrent with `in_start` is dropped, no `err`, results reflect only the post-start candidates.
- Reset mid-stream:
  - Stimulus: assert `rst_n`=0 at output bit 20.
  - Required: `out_valid`=`out_sad`=`busy`=0 immediately. A new `in_start` plus candidates produces a correct full stream.
- Parametric build NUM_CH=4, NUM_CAND=16, SAD_W=16, PT_W=4:
  - Stimulus: random SADs.
  - Required: 80-bit stream matching the reference-model minima. `out_sad`=0 in every cycle where `out_valid`=0.
